// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-stage bundle widths, field offsets inside
// the bundles, and the occupancy encoding reported by pipe_stage_reg.
package pipe_pkg;

  localparam int unsigned EXMEM_W = 140;
  localparam int unsigned MEMWB_W = 71;

  // EX/MEM bundle layout, MSB first.
  localparam int unsigned JUMP_BIT       = 139;
  localparam int unsigned JUMP_ADDR_MSB  = 138;
  localparam int unsigned JUMP_ADDR_LSB  = 107;
  localparam int unsigned DECODER_MSB    = 106;
  localparam int unsigned DECODER_LSB    = 75;
  localparam int unsigned ALU_RES_MSB    = 74;
  localparam int unsigned ALU_RES_LSB    = 43;
  localparam int unsigned RS2_DATA_MSB   = 42;
  localparam int unsigned RS2_DATA_LSB   = 11;
  localparam int unsigned RD_MSB         = 10;
  localparam int unsigned RD_LSB         = 6;
  localparam int unsigned MEM_WE_BIT     = 5;
  localparam int unsigned MEM_RE_BIT     = 4;
  localparam int unsigned REG_WE_BIT     = 3;
  localparam int unsigned FUNCT3_MSB     = 2;
  localparam int unsigned FUNCT3_LSB     = 0;

  typedef struct packed {
    logic        jump;
    logic [31:0] jump_addr;
    logic [31:0] decoder;
    logic [31:0] alu_res;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        mem_we;
    logic        mem_re;
    logic        reg_we;
    logic [2:0]  funct3;
  } exmem_t;

  // MEM/WB bundle layout, MSB first.
  localparam int unsigned WB_REG_WE_BIT  = 70;
  localparam int unsigned WB_RD_MSB      = 69;
  localparam int unsigned WB_RD_LSB      = 65;
  localparam int unsigned WB_DATA_MSB    = 64;
  localparam int unsigned WB_DATA_LSB    = 33;
  localparam int unsigned WB_PC_MSB      = 32;
  localparam int unsigned WB_PC_LSB      = 1;
  localparam int unsigned WB_TRAP_BIT    = 0;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] wb_data;
    logic [31:0] pc;
    logic        trap;
  } memwb_t;

  // Occupancy encoding of a stage register (entries held).
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, stall, flush
// and an optional 2-entry skid buffer that keeps in_ready_o registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = EXMEM_W,
  parameter bit                SKID       = 1'b1,
  parameter logic [DATA_W-1:0] FLUSH_DATA = '0
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  // Handshake: a beat moves in on a rising edge with in_valid_i & in_ready_o,
  // and out with out_valid_o & out_ready_i; flush_i at the same edge wins.
  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic              w_skid_valid;
  logic              w_in_ready;
  logic              w_in_fire;

  assign w_in_fire = in_valid_i & w_in_ready;

  if (SKID) begin : g_skid
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              w_main_free;

    // Main can take a new entry when empty or when its beat leaves this edge.
    assign w_main_free  = ~r_main_valid | out_ready_i;
    assign w_in_ready   = ~r_skid_valid;
    assign w_skid_valid = r_skid_valid;

    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        r_main_valid <= 1'b0;
        r_main_data  <= FLUSH_DATA;
      end else if (flush_i) begin
        r_main_valid <= 1'b0;
        r_main_data  <= FLUSH_DATA;
      end else if (w_main_free) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_data  <= r_skid_data;
        end else if (w_in_fire) begin
          r_main_valid <= 1'b1;
          r_main_data  <= in_data_i;
        end else begin
          r_main_valid <= 1'b0;
        end
      end
    end

    // The skid entry only ever holds a beat older than anything still upstream.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        r_skid_valid <= 1'b0;
        r_skid_data  <= FLUSH_DATA;
      end else if (flush_i) begin
        r_skid_valid <= 1'b0;
        r_skid_data  <= FLUSH_DATA;
      end else if (r_skid_valid) begin
        if (w_main_free) begin
          r_skid_valid <= 1'b0;
        end
      end else if (w_in_fire && !w_main_free) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= in_data_i;
      end
    end
  end else begin : g_single
    logic w_out_fire;

    assign w_out_fire   = r_main_valid & out_ready_i;
    assign w_in_ready   = ~r_main_valid | out_ready_i;
    assign w_skid_valid = 1'b0;

    // Data is left in place when a beat drains; only valid drops.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        r_main_valid <= 1'b0;
        r_main_data  <= FLUSH_DATA;
      end else if (flush_i) begin
        r_main_valid <= 1'b0;
        r_main_data  <= FLUSH_DATA;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data_i;
      end else if (w_out_fire) begin
        r_main_valid <= 1'b0;
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_main_valid;
  assign out_data_o  = r_main_data;
  assign occ_o       = occ_count(r_main_valid, w_skid_valid);

  a_single_occ : assert property (@(posedge clk_i) disable iff (!rst_n)
    (SKID || (occ_o != OCC_FULL)));

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_n)
    (out_valid_o && !out_ready_i && !flush_i) |=> (out_valid_o && $stable(out_data_o)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one plain-register instance and one skid instance,
// each checked every cycle against a FIFO model of its contents.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int W = EXMEM_W;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  // index 0: SKID=0, index 1: SKID=1
  logic [1:0]   flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data  [2];
  logic [W-1:0] out_data [2];
  logic [1:0]   occ      [2];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q_reg[$];
  logic [W-1:0] exp_q_skid[$];
  bit   [1:0]   took;
  bit   [1:0]   clean;
  bit           mon_en;

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b0)) u_reg (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
    .occ_o(occ[0])
  );

  pipe_stage_reg #(.DATA_W(W), .SKID(1'b1)) u_skid (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
    .occ_o(occ[1])
  );

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic string tag(input string s, input int k);
    return $sformatf("%s_%0d", s, k);
  endfunction

  // scoreboard queue helpers, k selects the instance
  function automatic int q_size(input int k);
    return (k == 1) ? exp_q_skid.size() : exp_q_reg.size();
  endfunction

  function automatic logic [W-1:0] q_front(input int k);
    return (k == 1) ? exp_q_skid[0] : exp_q_reg[0];
  endfunction

  function automatic void q_push(input int k, input logic [W-1:0] d);
    if (k == 1) exp_q_skid.push_back(d);
    else        exp_q_reg.push_back(d);
  endfunction

  function automatic void q_pop(input int k);
    if (k == 1) void'(exp_q_skid.pop_front());
    else        void'(exp_q_reg.pop_front());
  endfunction

  function automatic void q_clear(input int k);
    if (k == 1) exp_q_skid.delete();
    else        exp_q_reg.delete();
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Monitor on the falling edge: compare outputs with the model, then apply
  // what the coming rising edge will do to the model.
  always @(negedge clk_i) begin
    if (rst_n && mon_en) begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        bit exp_rdy;
        sz      = q_size(k);
        exp_rdy = (k == 1) ? (sz < 2) : ((sz == 0) || out_ready[k]);
        check(tag("occ", k), W'(occ[k]), W'(sz));
        check(tag("out_valid", k), W'(out_valid[k]), W'(sz > 0));
        check(tag("in_ready", k), W'(in_ready[k]), W'(exp_rdy));
        if (sz > 0)
          check(tag("out_data", k), out_data[k], q_front(k));
        else if (clean[k])
          check(tag("flush_data", k), out_data[k], '0);
        took[k] = 1'b0;
        if (flush[k]) begin
          q_clear(k);
          clean[k] = 1'b1;
          took[k]  = 1'b1;
        end else begin
          if ((sz > 0) && out_ready[k]) q_pop(k);
          if (in_valid[k] && exp_rdy) begin
            q_push(k, in_data[k]);
            clean[k] = 1'b0;
            took[k]  = 1'b1;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put(input int k, input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    do begin
      step();
      n++;
    end while (!took[k] && (n < 64));
    check(tag("put_accepted", k), W'(took[k]), W'(1));
    in_valid[k] = 1'b0;
  endtask

  initial begin
    flush      = '0;
    in_valid   = '0;
    out_ready  = '0;
    in_data[0] = '0;
    in_data[1] = '0;
    mon_en     = 1'b0;
    clean      = 2'b11;
    took       = '0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    for (int k = 0; k < 2; k++) begin
      check(tag("rst_out_valid", k), W'(out_valid[k]), '0);
      check(tag("rst_occ", k), W'(occ[k]), '0);
      check(tag("rst_in_ready", k), W'(in_ready[k]), W'(1));
      check(tag("rst_out_data", k), out_data[k], '0);
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // stream 1..8 through the skid stage with no stall
    out_ready[1] = 1'b1;
    for (int i = 1; i <= 8; i++) put(1, W'(i));
    repeat (3) step();

    // backpressure: A, B fill the stage, C waits upstream until release
    out_ready[1] = 1'b0;
    fork
      begin
        put(1, W'(32'hA));
        put(1, W'(32'hB));
        put(1, W'(32'hC));
      end
      begin
        repeat (5) step();
        out_ready[1] = 1'b1;
      end
    join
    repeat (4) step();

    // flush while full, with a beat D presented in the same cycle
    out_ready[1] = 1'b0;
    put(1, W'(32'h11));
    put(1, W'(32'h22));
    check("full_before_flush", W'(occ[1]), W'(OCC_FULL));
    in_valid[1] = 1'b1;
    in_data[1]  = W'(32'hD);
    flush[1]    = 1'b1;
    step();
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    check("flush_occ", W'(occ[1]), '0);
    check("flush_out_valid", W'(out_valid[1]), '0);
    check("flush_out_data", out_data[1], '0);
    out_ready[1] = 1'b1;
    repeat (3) step();

    // asynchronous reset between edges while full
    out_ready[1] = 1'b0;
    put(1, W'(32'h33));
    put(1, W'(32'h44));
    #2;
    rst_n = 1'b0;
    q_clear(0);
    q_clear(1);
    clean = 2'b11;
    #1;
    check("areset_out_valid", W'(out_valid[1]), '0);
    check("areset_occ", W'(occ[1]), '0);
    check("areset_out_data", out_data[1], '0);
    step();
    rst_n = 1'b1;
    out_ready[1] = 1'b1;
    put(1, W'(8'h5A));
    check("e_latency_valid", W'(out_valid[1]), W'(1));
    check("e_latency_data", out_data[1], W'(8'h5A));
    repeat (3) step();

    // plain register: continuous input while out_ready toggles
    fork
      begin
        for (int i = 0; i < 6; i++) put(0, W'(100 + i));
      end
      begin
        out_ready[0] = 1'b1; step();
        out_ready[0] = 1'b0; step();
        out_ready[0] = 1'b1; step();
        out_ready[0] = 1'b0; step();
        out_ready[0] = 1'b1;
      end
    join
    repeat (3) step();

    // random regression on both instances
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!in_valid[k] || took[k]) begin
          in_valid[k] = ($urandom_range(0, 3) != 0);
          in_data[k]  = rand_data();
        end
        out_ready[k] = ($urandom_range(0, 3) != 0);
        flush[k]     = ($urandom_range(0, 40) == 0);
      end
      step();
    end
    in_valid  = '0;
    flush     = '0;
    out_ready = 2'b11;
    repeat (5) step();
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
